// File: rtl/pixel_link_host.sv
// Host-side link master for the 16x16 ISFET readout core: chip reset, instruction shift-out,
// paced result capture into a first-word-fall-through FIFO. Optional PIX_TAG_EN prefixes pixel address tags.
module pixel_link_host #(
  parameter int unsigned WORD_WIDTH  = 18,
  parameter int unsigned ADC_BITS    = 18,
  parameter int unsigned FIFO_AW     = 4,
  parameter int unsigned RST_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYC = 65535,
`ifdef PIX_TAG_EN
  localparam int unsigned TAG_W      = 8,
`else
  localparam int unsigned TAG_W      = 0,
`endif
  localparam int unsigned OUT_W      = ADC_BITS + TAG_W
) (
  input  logic                  clk_ext,
  input  logic                  rst_ext,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [WORD_WIDTH-1:0] cmd_word,
  input  logic [15:0]           cmd_nsamp,
  output logic                  rstb_chip,
  output logic                  spi_si_ena,
  output logic                  din_4_fpga,
  output logic                  spi_fpga_wait,
  input  logic                  spi_so_flag,
  input  logic                  dout_2_fpga,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [OUT_W-1:0]      res_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err_timeout
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CNT_W = FIFO_AW + 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CRST = 3'd1;
  localparam logic [2:0] S_SEND = 3'd2;
  localparam logic [2:0] S_RECV = 3'd3;
  localparam logic [2:0] S_FRST = 3'd4;

  logic [2:0]            r_state, w_state_nxt;
  logic [15:0]           r_cnt, w_cnt_nxt;
  logic [WORD_WIDTH-1:0] r_word, w_word_nxt;
  logic [15:0]           r_nsamp, w_nsamp_nxt;
  logic [15:0]           r_rx_cnt, w_rx_nxt;
  logic [16:0]           r_idle_cnt, w_idle_nxt;
  logic                  r_collect, w_collect_nxt;
  logic [15:0]           r_bit_cnt, w_bit_nxt;
  logic [ADC_BITS-1:0]   r_shreg, w_shreg_nxt;
  logic                  r_err, w_err_nxt;
  logic                  r_flag, r_flag_d, r_dout;
  logic                  w_rise, w_sample, w_push, w_pop, w_done_nxt;

  logic [OUT_W-1:0]      r_mem [DEPTH];
  logic [FIFO_AW-1:0]    r_wr_ptr, r_rd_ptr, w_wr_nxt, w_rd_nxt;
  logic [CNT_W-1:0]      r_count, w_count_nxt, w_count_left;
  logic [OUT_W-1:0]      w_push_data, w_head_nxt;

  logic r_cmd_ready, r_rstb, r_si_ena, r_din, r_wait, r_res_valid, r_busy, r_done;
  logic w_ready_nxt, w_rstb_nxt, w_ena_nxt, w_din_nxt, w_wait_nxt;
  logic [OUT_W-1:0] r_res_data;

`ifdef PIX_TAG_EN
  logic [7:0] r_pix_addr, w_pix_nxt;
  logic       r_rot, w_rot_nxt;
`endif

  // A word starts on the rising edge of the aligned flag
  assign w_rise = r_flag && !r_flag_d;
  assign w_pop  = r_res_valid && res_ready;

  // Next-state, datapath and registered-output decode
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_word_nxt    = r_word;
    w_nsamp_nxt   = r_nsamp;
    w_rx_nxt      = r_rx_cnt;
    w_idle_nxt    = r_idle_cnt;
    w_collect_nxt = r_collect;
    w_bit_nxt     = r_bit_cnt;
    w_shreg_nxt   = r_shreg;
    w_err_nxt     = r_err;
    w_sample      = 1'b0;
    w_push        = 1'b0;
    w_done_nxt    = 1'b0;
`ifdef PIX_TAG_EN
    w_pix_nxt     = r_pix_addr;
    w_rot_nxt     = r_rot;
`endif
    case (r_state)
      S_IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          w_word_nxt  = cmd_word;
          w_nsamp_nxt = cmd_nsamp;
          w_rx_nxt    = '0;
          w_err_nxt   = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_CRST;
`ifdef PIX_TAG_EN
          w_pix_nxt   = cmd_word[7:0];
          w_rot_nxt   = cmd_word[WORD_WIDTH-1];
`endif
        end
      end
      S_CRST: begin
        if (r_cnt == 16'(RST_CYCLES)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_SEND;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_SEND: begin
        w_word_nxt = r_word << 1;
        if (r_cnt == 16'(WORD_WIDTH - 1)) begin
          w_cnt_nxt     = '0;
          w_idle_nxt    = '0;
          w_collect_nxt = 1'b0;
          w_state_nxt   = (r_nsamp == 16'd0) ? S_FRST : S_RECV;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_RECV: begin
        w_idle_nxt = r_idle_cnt + 17'd1;
        if (w_rise) begin
          w_idle_nxt    = '0;
          w_collect_nxt = 1'b1;
          w_bit_nxt     = 16'd1;
          w_sample      = 1'b1;
        end else if (r_collect && r_flag) begin
          w_bit_nxt = r_bit_cnt + 16'd1;
          w_sample  = 1'b1;
        end
        if (w_sample) w_shreg_nxt = ADC_BITS'({r_shreg, r_dout});
        if (w_sample && (w_bit_nxt == 16'(ADC_BITS))) begin
          w_push        = 1'b1;
          w_collect_nxt = 1'b0;
          w_rx_nxt      = r_rx_cnt + 16'd1;
`ifdef PIX_TAG_EN
          if (r_rot) w_pix_nxt = r_pix_addr + 8'd1;
`endif
          if (w_rx_nxt == r_nsamp) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_FRST;
          end
        end else if (w_idle_nxt >= 17'(TIMEOUT_CYC)) begin
          w_err_nxt     = 1'b1;
          w_collect_nxt = 1'b0;
          w_cnt_nxt     = '0;
          w_state_nxt   = S_FRST;
        end
      end
      S_FRST: begin
        if (r_cnt == 16'(RST_CYCLES - 1)) begin
          w_cnt_nxt   = '0;
          w_done_nxt  = !r_err;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

`ifdef PIX_TAG_EN
    w_push_data = {r_pix_addr, w_shreg_nxt};
`else
    w_push_data = w_shreg_nxt;
`endif
    w_wr_nxt     = r_wr_ptr + FIFO_AW'(w_push);
    w_rd_nxt     = r_rd_ptr + FIFO_AW'(w_pop);
    w_count_left = r_count - CNT_W'(w_pop);
    w_count_nxt  = w_count_left + CNT_W'(w_push);
    // The new head is the pushed word only when the FIFO would otherwise be empty
    w_head_nxt   = (w_push && (w_count_left == '0)) ? w_push_data : r_mem[w_rd_nxt];

    w_ready_nxt = (w_state_nxt == S_IDLE);
    w_rstb_nxt  = !(((w_state_nxt == S_CRST) && (w_cnt_nxt < 16'(RST_CYCLES))) ||
                    (w_state_nxt == S_FRST));
    w_ena_nxt   = (w_state_nxt == S_SEND);
    w_din_nxt   = w_ena_nxt && w_word_nxt[WORD_WIDTH-1];
    w_wait_nxt  = (w_state_nxt == S_RECV) && !w_collect_nxt &&
                  (w_count_nxt < CNT_W'(DEPTH)) && (w_rx_nxt < w_nsamp_nxt);
  end

  // State, datapath and output registers
  always_ff @(posedge clk_ext) begin
    if (rst_ext) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_word      <= '0;
      r_nsamp     <= '0;
      r_rx_cnt    <= '0;
      r_idle_cnt  <= '0;
      r_collect   <= 1'b0;
      r_bit_cnt   <= '0;
      r_shreg     <= '0;
      r_err       <= 1'b0;
      r_flag      <= 1'b0;
      r_flag_d    <= 1'b0;
      r_dout      <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_res_data  <= '0;
      r_cmd_ready <= 1'b1;
      r_rstb      <= 1'b1;
      r_si_ena    <= 1'b0;
      r_din       <= 1'b0;
      r_wait      <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef PIX_TAG_EN
      r_pix_addr  <= '0;
      r_rot       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_word      <= w_word_nxt;
      r_nsamp     <= w_nsamp_nxt;
      r_rx_cnt    <= w_rx_nxt;
      r_idle_cnt  <= w_idle_nxt;
      r_collect   <= w_collect_nxt;
      r_bit_cnt   <= w_bit_nxt;
      r_shreg     <= w_shreg_nxt;
      r_err       <= w_err_nxt;
      r_flag      <= spi_so_flag;
      r_flag_d    <= r_flag;
      r_dout      <= dout_2_fpga;
      r_wr_ptr    <= w_wr_nxt;
      r_rd_ptr    <= w_rd_nxt;
      r_count     <= w_count_nxt;
      r_res_data  <= w_head_nxt;
      r_cmd_ready <= w_ready_nxt;
      r_rstb      <= w_rstb_nxt;
      r_si_ena    <= w_ena_nxt;
      r_din       <= w_din_nxt;
      r_wait      <= w_wait_nxt;
      r_res_valid <= (w_count_nxt != '0);
      r_busy      <= !w_ready_nxt;
      r_done      <= w_done_nxt;
`ifdef PIX_TAG_EN
      r_pix_addr  <= w_pix_nxt;
      r_rot       <= w_rot_nxt;
`endif
    end
  end

  // FIFO storage carries no reset; validity is tracked by r_count
  always_ff @(posedge clk_ext) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  assign cmd_ready     = r_cmd_ready;
  assign rstb_chip     = r_rstb;
  assign spi_si_ena    = r_si_ena;
  assign din_4_fpga    = r_din;
  assign spi_fpga_wait = r_wait;
  assign res_valid     = r_res_valid;
  assign res_data      = r_res_data;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err_timeout   = r_err;

endmodule

// File: tb/tb_pixel_link_host.sv
// Scoreboard bench for pixel_link_host: directed commands, a behavioural chip model and
// monitors for the instruction stream, chip-reset pulses and the result FIFO.
`timescale 1ns/1ps
module tb_pixel_link_host;

  localparam int unsigned WW  = 18;
  localparam int unsigned AB  = 18;
  localparam int unsigned RC  = 8;
`ifdef PIX_TAG_EN
  localparam int unsigned TW  = 8;
`else
  localparam int unsigned TW  = 0;
`endif
  localparam int unsigned OW  = AB + TW;

  logic          clk_ext = 1'b0;
  logic          rst_ext = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [WW-1:0] cmd_word = '0;
  logic [15:0]   cmd_nsamp = '0;
  logic          rstb_chip, spi_si_ena, din_4_fpga, spi_fpga_wait;
  logic          spi_so_flag = 1'b0;
  logic          dout_2_fpga = 1'b0;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [OW-1:0] res_data;
  logic          busy, done, err_timeout;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [OW-1:0] q_res [$];
  logic [WW-1:0] q_cmd [$];

  pixel_link_host #(
    .WORD_WIDTH(WW), .ADC_BITS(AB), .FIFO_AW(1), .RST_CYCLES(RC), .TIMEOUT_CYC(100)
  ) dut (
    .clk_ext(clk_ext), .rst_ext(rst_ext), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_word(cmd_word), .cmd_nsamp(cmd_nsamp), .rstb_chip(rstb_chip), .spi_si_ena(spi_si_ena),
    .din_4_fpga(din_4_fpga), .spi_fpga_wait(spi_fpga_wait), .spi_so_flag(spi_so_flag),
    .dout_2_fpga(dout_2_fpga), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .done(done), .err_timeout(err_timeout)
  );

  always #5 clk_ext = ~clk_ext;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bounded wait expired or unexpected event", name);
  endtask

  function automatic logic [OW-1:0] mk(input logic [7:0] a, input logic [AB-1:0] w);
    return OW'({a, w});
  endfunction

  // Result scoreboard: every pop is compared against the oldest expected word
  always @(negedge clk_ext) begin
    if (res_valid && res_ready) begin
      if (q_res.size() == 0) fail_now("res_unexpected");
      else chk("res_data", 64'(res_data), 64'(q_res.pop_front()));
    end
    if (done) done_cnt++;
  end

  // Instruction stream collector
  logic [WW-1:0] si_sh = '0;
  int si_n = 0;
  always @(negedge clk_ext) begin
    if (spi_si_ena) begin
      si_sh = {si_sh[WW-2:0], din_4_fpga};
      si_n++;
    end else if (si_n > 0) begin
      chk("si_len", 64'(si_n), 64'(WW));
      if (q_cmd.size() == 0) fail_now("si_unexpected");
      else chk("si_word", 64'(si_sh), 64'(q_cmd.pop_front()));
      si_n = 0;
    end
  end

  // Chip reset pulse width
  int rst_run = 0;
  always @(negedge clk_ext) begin
    if (!rstb_chip) rst_run++;
    else if (rst_run > 0) begin
      chk("rstb_low_len", 64'(rst_run), 64'(RC));
      rst_run = 0;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_idle(input string p);
    chk({p, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    chk({p, "_busy"},      64'(busy),      64'd0);
    chk({p, "_rstb"},      64'(rstb_chip), 64'd1);
    chk({p, "_si_ena"},    64'(spi_si_ena), 64'd0);
    chk({p, "_din"},       64'(din_4_fpga), 64'd0);
    chk({p, "_wait"},      64'(spi_fpga_wait), 64'd0);
    chk({p, "_res_valid"}, 64'(res_valid), 64'd0);
    chk({p, "_done"},      64'(done),      64'd0);
    chk({p, "_err"},       64'(err_timeout), 64'd0);
  endtask

  task automatic issue(input logic [WW-1:0] w, input logic [15:0] n);
    int t;
    q_cmd.push_back(w);
    @(posedge clk_ext); #1;
    cmd_word = w; cmd_nsamp = n; cmd_valid = 1'b1;
    t = 0;
    while (t < 50) begin
      @(negedge clk_ext);
      if (cmd_ready) break;
      t++;
    end
    if (t >= 50) fail_now("cmd_accept");
    @(posedge clk_ext); #1;
    cmd_valid = 1'b0;
  endtask

  // Behavioural chip: waits for the host, then shifts one word MSB first
  task automatic chip_word(input logic [AB-1:0] w, input int extra, input logic [OW-1:0] exp);
    int t;
    t = 0;
    while (t < 1000) begin
      @(negedge clk_ext);
      if (spi_fpga_wait) break;
      t++;
    end
    if (t >= 1000) begin
      fail_now("chip_wait");
    end else begin
      q_res.push_back(exp);
      for (int i = AB - 1; i >= 0; i--) begin
        @(posedge clk_ext); #1;
        spi_so_flag = 1'b1; dout_2_fpga = w[i];
      end
      for (int k = 0; k < extra; k++) begin
        @(posedge clk_ext); #1;
      end
      @(posedge clk_ext); #1;
      spi_so_flag = 1'b0; dout_2_fpga = 1'b0;
      repeat (2) @(posedge clk_ext);
    end
  endtask

  task automatic wait_idle(input int bound);
    int t;
    t = 0;
    while (busy && t < bound) begin
      @(negedge clk_ext);
      t++;
    end
    if (busy) fail_now("wait_idle");
    repeat (2) @(negedge clk_ext);
  endtask

  initial begin
    int d0;
    int t;
    repeat (3) @(posedge clk_ext);
    #1 rst_ext = 1'b0;
    @(negedge clk_ext);
    chk_idle("reset");

    // Send-only command
    d0 = done_cnt;
    issue(18'h3_1205, 16'd0);
    wait_idle(200);
    chk("t1_done", 64'(done_cnt - d0), 64'd1);

    // Three result words, in order
    d0 = done_cnt;
    issue(18'h0_0010, 16'd3);
    chip_word(18'h2_AAAA, 0, mk(8'h10, 18'h2_AAAA));
    chip_word(18'h1_5555, 0, mk(8'h10, 18'h1_5555));
    chip_word(18'h0_0001, 0, mk(8'h10, 18'h0_0001));
    wait_idle(300);
    chk("t2_done", 64'(done_cnt - d0), 64'd1);

    // Back-pressure: two-entry FIFO fills, host withholds wait
    d0 = done_cnt;
    res_ready = 1'b0;
    issue(18'h0_0020, 16'd4);
    fork
      begin
        chip_word(18'h0_1111, 0, mk(8'h20, 18'h0_1111));
        chip_word(18'h0_2222, 0, mk(8'h20, 18'h0_2222));
        chip_word(18'h0_3333, 0, mk(8'h20, 18'h0_3333));
        chip_word(18'h0_4444, 0, mk(8'h20, 18'h0_4444));
      end
      begin
        repeat (100) @(negedge clk_ext);
        chk("t3_wait_full", 64'(spi_fpga_wait), 64'd0);
        chk("t3_res_valid", 64'(res_valid), 64'd1);
        chk("t3_pending", 64'(q_res.size()), 64'd2);
        res_ready = 1'b1;
      end
    join
    wait_idle(300);
    chk("t3_done", 64'(done_cnt - d0), 64'd1);

    // Flag held one extra cycle: still exactly one word
    d0 = done_cnt;
    issue(18'h0_0030, 16'd1);
    chip_word(18'h3_FFFF, 1, mk(8'h30, 18'h3_FFFF));
    wait_idle(200);
    chk("t4_done", 64'(done_cnt - d0), 64'd1);
    chk("t4_drained", 64'(q_res.size()), 64'd0);

    // Timeout with a silent chip
    d0 = done_cnt;
    issue(18'h0_0040, 16'd1);
    t = 0;
    while (!err_timeout && t < 400) begin
      @(negedge clk_ext);
      t++;
    end
    chk("t5_err_set", 64'(err_timeout), 64'd1);
    wait_idle(100);
    chk("t5_no_done", 64'(done_cnt - d0), 64'd0);
    chk("t5_err_sticky", 64'(err_timeout), 64'd1);
    d0 = done_cnt;
    issue(18'h0_0050, 16'd0);
    @(negedge clk_ext);
    chk("t5_err_clear", 64'(err_timeout), 64'd0);
    wait_idle(200);
    chk("t5_next_done", 64'(done_cnt - d0), 64'd1);

    // Rotating tags from 8'hFF, then reset while waiting for the third word
    issue(18'h2_00FF, 16'd3);
    chip_word(18'h1_2345, 0, mk(8'hFF, 18'h1_2345));
    chip_word(18'h0_ABCD, 0, mk(8'h00, 18'h0_ABCD));
    repeat (10) @(negedge clk_ext);
    chk("t6_drained", 64'(q_res.size()), 64'd0);
    chk("t6_busy", 64'(busy), 64'd1);
    @(posedge clk_ext); #1 rst_ext = 1'b1;
    @(posedge clk_ext); #1 rst_ext = 1'b0;
    @(negedge clk_ext);
    chk_idle("midrst");

    chk("cmd_queue_empty", 64'(q_cmd.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
